acc8_stream: RTL and testbench

Sequential 8-bit accumulator stage that sits directly upstream of the `adder8` ripple-carry adder. It feeds the running total and each incoming operand into `adder8` and registers the sum and carry it produces. A `start` pulse opens a burst, and the block accepts a programmable number of operands over a valid/ready handshake. It then holds the final total and a sticky overflow flag on a valid/ready result port until the total is consumed.

---
 rtl/acc8_stream.sv | 131 +++++++++++++
 tb/tb_acc8_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/acc8_stream.sv
// Burst accumulator in front of an 8-bit ripple-carry adder, with a valid/ready result port.
// Optional macro ACC8_SAT_EN: saturate the running total to 0xFF once any carry-out occurs.

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       overflow
);
  logic [8:0] w_carry;

  always_comb begin
    w_carry    = '0;
    sum        = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
    overflow = w_carry[8];
  end
endmodule

module acc8_stream #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_sum,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_acc;
  logic             r_sticky;
  logic [LEN_W-1:0] r_remaining;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [7:0]       w_sum;
  logic             w_carry_out;
  logic [7:0]       w_acc_next;

  adder8 u_adder8 (
    .a        (r_acc),
    .b        (in_data),
    .sum      (w_sum),
    .overflow (w_carry_out)
  );

`ifdef ACC8_SAT_EN
  assign w_acc_next = (w_carry_out || r_sticky) ? 8'hFF : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  // Handshake flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_remaining <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_remaining <= burst_len;
            r_busy      <= 1'b1;
            if (burst_len == '0) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc       <= w_acc_next;
            r_sticky    <= r_sticky | w_carry_out;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LEN_W'(1)) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign out_sum      = r_acc;
  assign out_overflow = r_sticky;
endmodule

// File: tb/tb_acc8_stream.sv
// Directed-vector bench for acc8_stream; expectations are hand-computed per step.

module tb_acc8_stream;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] burst_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int total;
  int bad;

  acc8_stream #(.LEN_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_len    (burst_len),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic vld, input logic bsy);
    chk({tag, "_in_ready"}, {7'd0, in_ready}, {7'd0, rdy});
    chk({tag, "_out_valid"}, {7'd0, out_valid}, {7'd0, vld});
    chk({tag, "_busy"}, {7'd0, busy}, {7'd0, bsy});
  endtask

  initial begin
    logic [7:0] ovf_sum_exp;
    total = 0;
    bad   = 0;
`ifdef ACC8_SAT_EN
    ovf_sum_exp = 8'hFF;
`else
    ovf_sum_exp = 8'hFE;
`endif

    // Reset with random inputs
    rst_n     = 1'b0;
    start     = 1'($urandom);
    burst_len = 4'($urandom);
    in_data   = 8'($urandom);
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    tick();
    start     = 1'($urandom);
    in_valid  = 1'($urandom);
    in_data   = 8'($urandom);
    tick();
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_sum", out_sum, 8'h00);
    chk("reset_ovf", {7'd0, out_overflow}, 8'h00);

    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick();
    chk_flags("idle", 1'b0, 1'b0, 1'b0);

    // Basic burst: 0x01 + 0x21 + 0x08 = 0x2A
    start = 1'b1; burst_len = 4'd3;
    tick();
    start = 1'b0;
    chk_flags("basic_open", 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h21; tick();
    in_data = 8'h08; tick();
    in_valid = 1'b0;
    chk_flags("basic_done", 1'b0, 1'b1, 1'b1);
    chk("basic_sum", out_sum, 8'h2A);
    chk("basic_ovf", {7'd0, out_overflow}, 8'h00);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_flags("basic_release", 1'b0, 1'b0, 1'b0);

    // Overflow burst: 0xFF + 0xFF
    start = 1'b1; burst_len = 4'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; tick();
    chk("ovf_first_sum", out_sum, 8'hFF);
    chk("ovf_first_flag", {7'd0, out_overflow}, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("ovf_sum", out_sum, ovf_sum_exp);
    chk("ovf_flag", {7'd0, out_overflow}, 8'h01);
    chk("ovf_valid", {7'd0, out_valid}, 8'h01);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: four 0x10 operands with gaps, then held result
    start = 1'b1; burst_len = 4'd4;
    tick();
    start = 1'b0; in_data = 8'h10;
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk("bp_gap_sum", out_sum, 8'h10);
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    chk_flags("bp_gap", 1'b1, 1'b0, 1'b1);
    chk("bp_gap2_sum", out_sum, 8'h20);
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk_flags("bp_mid", 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; tick();
    in_valid = 1'b0;
    chk("bp_sum", out_sum, 8'h40);
    for (int i = 0; i < 5; i++) begin
      start     = (i == 1);
      burst_len = 4'd2;
      in_valid  = (i == 2);
      in_data   = 8'hAA;
      tick();
      chk_flags("bp_hold", 1'b0, 1'b1, 1'b1);
      chk("bp_hold_sum", out_sum, 8'h40);
      chk("bp_hold_ovf", {7'd0, out_overflow}, 8'h00);
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_flags("bp_release", 1'b0, 1'b0, 1'b0);
    tick();
    chk_flags("bp_idle", 1'b0, 1'b0, 1'b0);
    chk("bp_idle_sum", out_sum, 8'h40);

    // Zero-length burst
    start = 1'b1; burst_len = 4'd0;
    tick();
    start = 1'b0;
    chk_flags("zero", 1'b0, 1'b1, 1'b1);
    chk("zero_sum", out_sum, 8'h00);
    chk("zero_ovf", {7'd0, out_overflow}, 8'h00);
    in_valid = 1'b1; in_data = 8'h33; tick();
    in_valid = 1'b0;
    chk("zero_noaccept_sum", out_sum, 8'h00);
    chk("zero_still_valid", {7'd0, out_valid}, 8'h01);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_flags("zero_release", 1'b0, 1'b0, 1'b0);

    // Mid-burst reset then a fresh burst
    start = 1'b1; burst_len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h80; tick();
    in_valid = 1'b0;
    chk("mid_partial_sum", out_sum, 8'h80);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_flags("mid_reset", 1'b0, 1'b0, 1'b0);
    chk("mid_reset_sum", out_sum, 8'h00);
    chk("mid_reset_ovf", {7'd0, out_overflow}, 8'h00);
    start = 1'b1; burst_len = 4'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h05; tick();
    in_data = 8'h06; tick();
    in_valid = 1'b0;
    chk("mid_new_sum", out_sum, 8'h0B);
    chk("mid_new_ovf", {7'd0, out_overflow}, 8'h00);
    chk("mid_new_valid", {7'd0, out_valid}, 8'h01);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_flags("mid_release", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
